// File: rtl/ysyx_220053_div_ctrl_pkg.sv
// Shared divider types: FSM state, latched op bundle,
// default widths and special-case result constants.
package ysyx_220053_div_ctrl_pkg;

    localparam int XLEN_D = 64;
    localparam int WLEN_D = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    typedef struct packed {
        logic word;
        logic rem;
        logic neg_q;
        logic neg_r;
    } div_op_t;

    localparam logic [XLEN_D-1:0] DIV0_QUOT = '1;
    localparam logic [XLEN_D-1:0] OVF_REM   = '0;

endpackage

// File: rtl/ysyx_220053_div_ctrl_step.sv
// One restoring shift-subtract step of the divider.
// Relies on rem < div so the shifted remainder fits XLEN+1 bits.
module ysyx_220053_div_ctrl_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] div,
    output logic [XLEN-1:0] rem_nxt,
    output logic [XLEN-1:0] quo_nxt
);

    logic [XLEN:0] part;
    logic [XLEN:0] diff;

    assign part    = {rem, quo[XLEN-1]};
    assign diff    = part - {1'b0, div};
    assign rem_nxt = diff[XLEN] ? part[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_nxt = {quo[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/ysyx_220053_div_ctrl.sv
// Iterative restoring divider controller for div/divu/rem/remu
// and their word forms; one quotient bit per cycle.
module ysyx_220053_div_ctrl
    import ysyx_220053_div_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_D,
    parameter int WLEN = WLEN_D
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            op_signed,
    input  logic            op_word,
    input  logic            op_rem,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam int HW = XLEN - WLEN;
    localparam logic [CW-1:0] XSTEPS = CW'(XLEN);
    localparam logic [CW-1:0] WSTEPS = CW'(WLEN);
    localparam logic [CW-1:0] LAST   = CW'(1);

    div_state_t      state;
    div_op_t         op_q;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] div_q;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] quo_nxt;

    logic [XLEN-1:0] a_sx;
    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic [XLEN-1:0] q_init;
    logic            a_neg;
    logic            b_neg;
    logic            b_zero;
    logic            ovf;

    logic [XLEN-1:0] sel;
    logic [XLEN-1:0] fixed;
    logic [XLEN-1:0] res_fin;
    logic            neg;

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    // Operands brought to the operating width; word dividends sit
    // in the top half so they shift out first.
    always_comb begin
        a_sx   = op_word ? {{HW{dividend[WLEN-1]}}, dividend[WLEN-1:0]}
                         : dividend;
        a_ext  = (op_word && !op_signed)
                 ? {{HW{1'b0}}, dividend[WLEN-1:0]} : a_sx;
        b_ext  = !op_word ? divisor
               : op_signed ? {{HW{divisor[WLEN-1]}}, divisor[WLEN-1:0]}
                           : {{HW{1'b0}}, divisor[WLEN-1:0]};
        a_neg  = op_signed & a_ext[XLEN-1];
        b_neg  = op_signed & b_ext[XLEN-1];
        a_abs  = a_neg ? -a_ext : a_ext;
        b_abs  = b_neg ? -b_ext : b_ext;
        q_init = op_word ? {a_abs[WLEN-1:0], {HW{1'b0}}} : a_abs;
        b_zero = (b_ext == '0);
        ovf    = op_signed && (b_ext == '1) && a_ext[XLEN-1]
                 && (op_word ? (a_ext[WLEN-2:0] == '0)
                             : (a_ext[XLEN-2:0] == '0));
    end

    always_comb begin
        sel     = op_q.rem ? rem_nxt : quo_nxt;
        neg     = op_q.rem ? op_q.neg_r : op_q.neg_q;
        fixed   = neg ? -sel : sel;
        res_fin = op_q.word ? {{HW{fixed[WLEN-1]}}, fixed[WLEN-1:0]}
                            : fixed;
    end

    ysyx_220053_div_ctrl_step #(
        .XLEN(XLEN)
    ) u_step (
        .rem    (rem_q),
        .quo    (quo_q),
        .div    (div_q),
        .rem_nxt(rem_nxt),
        .quo_nxt(quo_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            op_q      <= '0;
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            out_valid <= 1'b0;
            result    <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (in_valid) begin
                    op_q <= '{word:  op_word,
                              rem:   op_rem,
                              neg_q: a_neg ^ b_neg,
                              neg_r: a_neg};
                    unique case (1'b1)
                        b_zero: begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            result    <= op_rem ? a_sx : DIV0_QUOT;
                        end
                        ovf: begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            result    <= op_rem ? OVF_REM : a_sx;
                        end
                        default: begin
                            state <= S_CALC;
                            rem_q <= '0;
                            quo_q <= q_init;
                            div_q <= b_abs;
                            cnt   <= op_word ? WSTEPS : XSTEPS;
                        end
                    endcase
                end
                S_CALC: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt   <= cnt - LAST;
                    if (cnt == LAST) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        result    <= res_fin;
                    end
                end
                S_DONE: if (out_ready) begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_220053_div_ctrl.sv
// Directed and randomized bench for the divider controller,
// checked against an arithmetic reference model.
module tb_ysyx_220053_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic        op_signed = 1'b0;
    logic        op_word = 1'b0;
    logic        op_rem = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_220053_div_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dividend (dividend),
        .divisor  (divisor),
        .op_signed(op_signed),
        .op_word  (op_word),
        .op_rem   (op_rem),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .busy     (busy)
    );

    initial begin
        #1000000;
        $display("FAIL timeout: summary never reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // RISC-V M-extension semantics written with plain arithmetic.
    function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                  input logic s, input logic w, input logic r,
                                  output logic [63:0] res, output int lat);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              sa32, sb32;
        int unsigned     ua32, ub32;
        logic [63:0]     q, m;
        logic [31:0]     q32, m32;
        if (w) begin
            lat  = 33;
            ua32 = a[31:0];
            ub32 = b[31:0];
            sa32 = a[31:0];
            sb32 = b[31:0];
            if (ub32 == 0) begin
                q32 = 32'hFFFF_FFFF; m32 = ua32; lat = 1;
            end else if (s && ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) begin
                q32 = ua32; m32 = 32'd0; lat = 1;
            end else if (s) begin
                q32 = sa32 / sb32; m32 = sa32 % sb32;
            end else begin
                q32 = ua32 / ub32; m32 = ua32 % ub32;
            end
            res = r ? {{32{m32[31]}}, m32} : {{32{q32[31]}}, q32};
        end else begin
            lat = 65;
            ua  = a;
            ub  = b;
            sa  = a;
            sb  = b;
            if (ub == 0) begin
                q = '1; m = ua; lat = 1;
            end else if (s && ua == 64'h8000_0000_0000_0000 && ub == '1) begin
                q = ua; m = '0; lat = 1;
            end else if (s) begin
                q = sa / sb; m = sa % sb;
            end else begin
                q = ua / ub; m = ua % ub;
            end
            res = r ? m : q;
        end
    endfunction

    task automatic issue(input logic [63:0] a, input logic [63:0] b,
                         input logic s, input logic w, input logic r);
        check("in_ready_before_issue", 64'(in_ready), 64'd1);
        dividend  = a;
        divisor   = b;
        op_signed = s;
        op_word   = w;
        op_rem    = r;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [63:0] a,
                          input logic [63:0] b, input logic s,
                          input logic w, input logic r,
                          input logic [63:0] exp_res, input int exp_lat);
        int cyc;
        issue(a, b, s, w, r);
        wait_out(cyc);
        check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        check({tag, "_res"}, result, exp_res);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_idle"}, 64'({in_ready, busy, out_valid}), 64'd4);
    endtask

    initial begin
        int          cyc;
        logic        seen;
        logic [63:0] a, b, exp;
        logic        s, w, r;
        int          lat, kind;

        repeat (2) @(posedge clk);
        #1;
        check("rst_flags", 64'({in_ready, busy, out_valid}), 64'd4);
        check("rst_result", result, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_op("udiv", 64'd100, 64'd7, 0, 0, 0, 64'd14, 65);
        run_op("urem", 64'd100, 64'd7, 0, 0, 1, 64'd2, 65);
        run_op("sdivw", 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002,
               1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFD, 33);
        run_op("sremw", 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002,
               1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        run_op("div0q", 64'd5, 64'd0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("div0r", 64'd5, 64'd0, 0, 0, 1, 64'd5, 1);
        run_op("ovfq", 64'h8000_0000_0000_0000, '1, 1, 0, 0,
               64'h8000_0000_0000_0000, 1);
        run_op("ovfr", 64'h8000_0000_0000_0000, '1, 1, 0, 1, 64'd0, 1);

        // Consumer stall with a competing request held high.
        issue(64'd1000, 64'd9, 0, 0, 0);
        wait_out(cyc);
        check("stall_lat", 64'(cyc), 64'd65);
        check("stall_first", result, 64'd111);
        dividend = 64'd1;
        divisor  = 64'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("stall_flags", 64'({in_ready, busy, out_valid}), 64'd3);
            check("stall_res", result, 64'd111);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("stall_release", 64'({in_ready, busy, out_valid}), 64'd4);

        // Flush mid-CALC, then a fresh request.
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 0, 0, 0);
        repeat (19) begin
            @(posedge clk); #1;
        end
        check("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_calc", 64'({in_ready, busy, out_valid}), 64'd4);
        run_op("after_flush", 64'd3, 64'd1, 0, 0, 0, 64'd3, 65);

        // Flush beats a simultaneous request.
        dividend = 64'd10;
        divisor  = 64'd2;
        flush    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_vs_req", 64'({in_ready, busy, out_valid}), 64'd4);

        // Flush beats out_ready in DONE.
        issue(64'd9, 64'd0, 0, 0, 0);
        check("flush_done_pre", 64'(out_valid), 64'd1);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        flush     = 1'b0;
        out_ready = 1'b0;
        check("flush_done", 64'({in_ready, busy, out_valid}), 64'd4);

        // Reset mid-CALC must never surface a result.
        issue(64'd12345, 64'd67, 0, 0, 0);
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("rst_mid_flags", 64'({in_ready, busy, out_valid}), 64'd4);
        check("rst_mid_result", result, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("rst_mid_quiet", 64'(seen), 64'd0);

        // Reset in DONE drops the pending result.
        issue(64'd4, 64'd0, 0, 0, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("rst_done", 64'({in_ready, busy, out_valid}), 64'd4);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            s    = 1'($urandom_range(0, 1));
            w    = 1'($urandom_range(0, 1));
            r    = 1'($urandom_range(0, 1));
            a    = {$urandom, $urandom};
            b    = {$urandom, $urandom};
            if (kind == 0) begin
                b = w ? {b[63:32], 32'd0} : 64'd0;
            end else if (kind == 1) begin
                s = 1'b1;
                a = w ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
                b = w ? {b[63:32], 32'hFFFF_FFFF} : '1;
            end else if (kind < 5) begin
                b = w ? {b[63:32], 32'($urandom_range(1, 1000))}
                      : 64'($urandom_range(1, 1000));
            end else if (kind == 5) begin
                s = 1'b1;
                b = -64'($urandom_range(1, 1000));
            end
            model(a, b, s, w, r, exp, lat);
            run_op("rand", a, b, s, w, r, exp, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
